// File: rtl/lock_pkg.sv
`default_nettype none
//----------------------------------------------------------------------------
// lock_pkg: FSM state type and default timing for the lock input conditioner.
// Rev 1.0
//----------------------------------------------------------------------------
package lock_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 16;
  localparam int PULSE_CYCLES_DEF    = 4;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARMED     = 3'd1,
    DRIVE_DIG = 3'd2,
    GAP       = 3'd3,
    DRIVE_ST  = 3'd4
  } lock_state_e;

endpackage
`default_nettype wire

// File: rtl/lock_debounce.sv
`default_nettype none
//----------------------------------------------------------------------------
// lock_debounce: 2-flop synchronizer, stable-sample debouncer, press pulse.
// Rev 1.0
//----------------------------------------------------------------------------
module lock_debounce
  import lock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic press_o
);

  localparam logic [15:0] c_last = 16'(DEBOUNCE_CYCLES - 1);

  logic        sync1_q;
  logic        sync2_q;
  logic        level_q;
  logic        level_d;
  logic        press_q;
  logic        press_d;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  // Counter runs only while the synchronized sample disagrees with the accepted level.
  always_comb begin
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = 16'd0;
    if (sync2_q != level_q) begin
      if (cnt_q == c_last) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= 16'd0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press_o = press_q;

endmodule
`default_nettype wire

// File: rtl/lock_input_conditioner.sv
`default_nettype none
//----------------------------------------------------------------------------
// lock_input_conditioner: debounced buttons to digit/strobe pulse sequences.
// Rev 1.0
//----------------------------------------------------------------------------
module lock_input_conditioner
  import lock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int PULSE_CYCLES    = PULSE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_one,
  input  logic btn_zero,
  input  logic btn_enter,
  output logic one,
  output logic zero,
  output logic st,
  output logic armed,
  output logic busy,
  output logic err
);

  localparam logic [7:0] c_pulse_last = 8'(PULSE_CYCLES - 1);

  logic        w_one_ev;
  logic        w_zero_ev;
  logic        w_enter_ev;
  logic        w_conflict;
  logic        w_digit_ev;
  logic        w_phase_done;

  lock_state_e state_q;
  logic        digit_q;
  logic [7:0]  cnt_q;
  logic        one_q;
  logic        zero_q;
  logic        st_q;
  logic        armed_q;
  logic        busy_q;
  logic        err_q;

  lock_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_one (
    .clk     (clk),
    .rst     (rst),
    .raw_i   (btn_one),
    .press_o (w_one_ev)
  );

  lock_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_zero (
    .clk     (clk),
    .rst     (rst),
    .raw_i   (btn_zero),
    .press_o (w_zero_ev)
  );

  lock_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_enter (
    .clk     (clk),
    .rst     (rst),
    .raw_i   (btn_enter),
    .press_o (w_enter_ev)
  );

  assign w_conflict   = w_one_ev & w_zero_ev;
  assign w_digit_ev   = w_one_ev | w_zero_ev;
  assign w_phase_done = (cnt_q == c_pulse_last);

  // Outputs are loaded together with the state they belong to, so they track it exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      digit_q <= 1'b0;
      cnt_q   <= 8'd0;
      one_q   <= 1'b0;
      zero_q  <= 1'b0;
      st_q    <= 1'b0;
      armed_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (w_conflict) begin
            err_q <= 1'b1;
          end else if (w_digit_ev) begin
            digit_q <= w_one_ev;
            state_q <= ARMED;
            armed_q <= 1'b1;
            cnt_q   <= 8'd0;
          end
        end
        ARMED: begin
          if (w_conflict) begin
            err_q <= 1'b1;
          end else if (w_enter_ev) begin
            state_q <= DRIVE_DIG;
            armed_q <= 1'b0;
            busy_q  <= 1'b1;
            one_q   <= digit_q;
            zero_q  <= ~digit_q;
            cnt_q   <= 8'd0;
          end else if (w_digit_ev) begin
            digit_q <= w_one_ev;
          end
        end
        DRIVE_DIG: begin
          if (w_phase_done) begin
            state_q <= GAP;
            one_q   <= 1'b0;
            zero_q  <= 1'b0;
            cnt_q   <= 8'd0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        GAP: begin
          if (w_phase_done) begin
            state_q <= DRIVE_ST;
            st_q    <= 1'b1;
            cnt_q   <= 8'd0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        DRIVE_ST: begin
          if (w_phase_done) begin
            state_q <= IDLE;
            st_q    <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= 8'd0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          one_q   <= 1'b0;
          zero_q  <= 1'b0;
          st_q    <= 1'b0;
          armed_q <= 1'b0;
          busy_q  <= 1'b0;
          cnt_q   <= 8'd0;
        end
      endcase
    end
  end

  assign one   = one_q;
  assign zero  = zero_q;
  assign st    = st_q;
  assign armed = armed_q;
  assign busy  = busy_q;
  assign err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_lock_input_conditioner.sv
`default_nettype none
//----------------------------------------------------------------------------
// tb_lock_input_conditioner: directed vector table, corner sequences, random run.
// Rev 1.0
//----------------------------------------------------------------------------
module tb_lock_input_conditioner;

  localparam int D = 4;
  localparam int P = 3;
  localparam int N = 1500;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic b1  = 1'b0;
  logic b0  = 1'b0;
  logic be  = 1'b0;
  logic one, zero, st, armed, busy, err;

  int total = 0;
  int bad   = 0;

  lock_input_conditioner #(.DEBOUNCE_CYCLES(D), .PULSE_CYCLES(P)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_one   (b1),
    .btn_zero  (b0),
    .btn_enter (be),
    .one       (one),
    .zero      (zero),
    .st        (st),
    .armed     (armed),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Vector record: buttons {one,zero,enter}, cycles held, expected {one,zero,st,armed,busy,err}.
  // hold==0 marks a reset applied with the given buttons driven.
  typedef struct {
    logic [2:0] btn;
    int         hold;
    logic [5:0] exp;
    int         grp;
  } vec_t;

  vec_t tbl[$];

  bit raw[3][N];
  bit rec = 1'b0;
  int st_rises = 0;
  bit dig_q[$];
  logic one_p = 1'b0, zero_p = 1'b0, st_p = 1'b0;

  function automatic logic [5:0] outs();
    return {one, zero, st, armed, busy, err};
  endfunction

  task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%b expected=%b at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic step(input logic [2:0] btn, input int hold, input logic [5:0] exp, input string name);
    for (int i = 0; i < hold; i++) begin
      {b1, b0, be} = btn;
      @(posedge clk);
      #1;
      check(name, outs(), exp);
    end
  endtask

  task automatic drive(input logic [2:0] btn, input int n);
    for (int i = 0; i < n; i++) begin
      {b1, b0, be} = btn;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic [2:0] btn, input string name);
    {b1, b0, be} = btn;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check(name, outs(), 6'b000000);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic add(input logic [2:0] btn, input int hold, input logic [5:0] exp, input int grp);
    vec_t v;
    v.btn = btn; v.hold = hold; v.exp = exp; v.grp = grp;
    tbl.push_back(v);
  endtask

  // Press event seen by the FSM at edge c: a clean rise sampled at c-2-D held for D samples.
  function automatic bit ev(input int b, input int c);
    int e0 = c - 2 - D;
    if (e0 < 1) return 1'b0;
    if (!raw[b][e0] || raw[b][e0-1]) return 1'b0;
    for (int k = 0; k < D; k++) if (!raw[b][e0+k]) return 1'b0;
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      total++;
      if ((32'(one) + 32'(zero) + 32'(st)) > 1) begin
        bad++;
        $display("FAIL exclusive: one=%b zero=%b st=%b required at most one high", one, zero, st);
      end
    end
    if (rec) begin
      if (one && !one_p) dig_q.push_back(1'b1);
      if (zero && !zero_p) dig_q.push_back(1'b0);
      if (st && !st_p) st_rises++;
    end
    one_p  <= one;
    zero_p <= zero;
    st_p   <= st;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seq[6];
    int bs, k, pos, lo, hi;
    bit m_arm, m_dig, s_dig, e1, e0v, ee, inb, merr, mb;
    logic [5:0] ex;

    // Zero press then enter: full digit/gap/strobe waveform.
    add(3'b010, 6, 6'b000000, 1); add(3'b010, 1, 6'b000100, 1); add(3'b010, 13, 6'b000100, 1);
    add(3'b001, 6, 6'b000100, 1); add(3'b001, 1, 6'b010010, 1); add(3'b001, 2, 6'b010010, 1);
    add(3'b001, 1, 6'b000010, 1); add(3'b001, 2, 6'b000010, 1); add(3'b001, 1, 6'b001010, 1);
    add(3'b001, 2, 6'b001010, 1); add(3'b001, 1, 6'b000000, 1); add(3'b001, 3, 6'b000000, 1);
    add(3'b000, 10, 6'b000000, 1);
    add(3'b000, 0, 6'b000000, 1);
    // Simultaneous one+zero: single err pulse, later enter ignored.
    add(3'b110, 6, 6'b000000, 2); add(3'b110, 1, 6'b000001, 2); add(3'b110, 3, 6'b000000, 2);
    add(3'b000, 10, 6'b000000, 2); add(3'b001, 10, 6'b000000, 2); add(3'b000, 12, 6'b000000, 2);
    add(3'b000, 0, 6'b000000, 2);
    // One then zero then enter: zero sent; one pressed during DRIVE_ST is dropped.
    add(3'b100, 6, 6'b000000, 3); add(3'b100, 2, 6'b000100, 3); add(3'b000, 8, 6'b000100, 3);
    add(3'b010, 8, 6'b000100, 3); add(3'b000, 8, 6'b000100, 3); add(3'b001, 6, 6'b000100, 3);
    add(3'b001, 2, 6'b010010, 3); add(3'b100, 1, 6'b010010, 3); add(3'b100, 3, 6'b000010, 3);
    add(3'b100, 3, 6'b001010, 3); add(3'b100, 5, 6'b000000, 3); add(3'b000, 10, 6'b000000, 3);
    // Button held through reset release is a fresh press.
    add(3'b100, 0, 6'b000000, 4);
    add(3'b100, 6, 6'b000000, 4); add(3'b100, 1, 6'b000100, 4); add(3'b000, 10, 6'b000100, 4);
    add(3'b000, 0, 6'b000000, 4);

    do_reset(3'b000, "reset_init");
    foreach (tbl[i]) begin
      if (tbl[i].hold == 0) do_reset(tbl[i].btn, $sformatf("reset_g%0d", tbl[i].grp));
      else step(tbl[i].btn, tbl[i].hold, tbl[i].exp, $sformatf("vec_g%0d_%0d", tbl[i].grp, i));
    end

    // Bouncing one button: never accepted.
    for (int i = 0; i < 30; i++) begin
      {b1, b0, be} = {i[0], 2'b00};
      @(posedge clk);
      #1;
      check("toggle", outs(), 6'b000000);
    end
    step(3'b000, 10, 6'b000000, "toggle_tail");

    // Async reset in the second GAP cycle aborts the sequence.
    step(3'b100, 6, 6'b000000, "rst_mid_arm");
    step(3'b100, 2, 6'b000100, "rst_mid_arm");
    step(3'b000, 8, 6'b000100, "rst_mid_arm");
    step(3'b001, 6, 6'b000100, "rst_mid_arm");
    step(3'b001, 3, 6'b100010, "rst_mid_dig");
    step(3'b000, 2, 6'b000010, "rst_mid_gap");
    #2 rst = 1'b1;
    #1 check("rst_async", outs(), 6'b000000);
    @(posedge clk);
    #1;
    check("rst_edge", outs(), 6'b000000);
    rst = 1'b0;
    step(3'b000, 20, 6'b000000, "rst_after");

    // Six back-to-back digits.
    seq = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    rec = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(seq[i] ? 3'b100 : 3'b010, 8);
      drive(3'b000, 8);
      drive(3'b001, 8);
      drive(3'b000, 12);
    end
    @(negedge clk);
    rec = 1'b0;
    check("six_st_count", 6'(st_rises), 6'd6);
    check("six_dig_count", 6'(dig_q.size()), 6'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < dig_q.size()) check($sformatf("six_dig%0d", i), {5'd0, dig_q[i]}, {5'd0, seq[i]});
    end

    // Randomized well-formed presses and glitches against a timeline model.
    for (int b = 0; b < 3; b++) begin
      for (int c = 0; c < N; c++) raw[b][c] = 1'b0;
      pos = 0;
      while (pos < N) begin
        lo = int'($urandom_range(D + 12, D + 2));
        pos += lo;
        if ($urandom_range(3, 0) == 0) hi = int'($urandom_range(D - 1, 1));
        else hi = int'($urandom_range(D + 10, D + 1));
        for (int j = 0; j < hi; j++) begin
          if (pos < N) raw[b][pos] = 1'b1;
          pos++;
        end
      end
    end
    {b1, b0, be} = 3'b000;
    @(posedge clk);
    #1;
    do_reset(3'b000, "reset_rand");
    bs = -1000; m_arm = 1'b0; m_dig = 1'b0; s_dig = 1'b0;
    for (int c = 0; c < N; c++) begin
      {b1, b0, be} = {raw[0][c], raw[1][c], raw[2][c]};
      @(posedge clk);
      #1;
      e1 = ev(0, c); e0v = ev(1, c); ee = ev(2, c);
      inb  = (c > bs) && (c <= bs + 3 * P);
      merr = 1'b0;
      if (!inb) begin
        if (e1 && e0v) merr = 1'b1;
        else if (m_arm && ee) begin
          bs = c; s_dig = m_dig; m_arm = 1'b0;
        end else if (e1 || e0v) begin
          m_dig = e1; m_arm = 1'b1;
        end
      end
      k  = c - bs;
      mb = (k >= 0) && (k < 3 * P);
      ex = {mb && (k < P) && s_dig, mb && (k < P) && !s_dig, mb && (k >= 2 * P), m_arm, mb, merr};
      check($sformatf("rand_c%0d", c), outs(), ex);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
